// File: rtl/cpu_pkg.sv
// Shared CoreBassier definitions: opcode values, sequencer state encoding and
// opcode class helpers used by the control blocks.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXECUTE   = 4'd2,
        ST_MEMORY    = 4'd3,
        ST_WRITEBACK = 4'd4,
        ST_WAIT_IN   = 4'd5,
        ST_WAIT_OUT  = 4'd6,
        ST_HALTED    = 4'd7,
        ST_FAULT     = 4'd8
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_ALU_LAST = 6'h0F;
    localparam logic [5:0] OP_IMM_FIRST = 6'h10;
    localparam logic [5:0] OP_IMM_LAST  = 6'h13;
    localparam logic [5:0] OP_LOAD  = 6'h14;
    localparam logic [5:0] OP_STORE = 6'h15;
    localparam logic [5:0] OP_JUMP  = 6'h16;
    localparam logic [5:0] OP_BEQ   = 6'h17;
    localparam logic [5:0] OP_BNE   = 6'h18;
    localparam logic [5:0] OP_NOP   = 6'h19;
    localparam logic [5:0] OP_HALT  = 6'h1A;
    localparam logic [5:0] OP_IN    = 6'h1B;
    localparam logic [5:0] OP_OUT   = 6'h1C;
    localparam logic [5:0] OP_MOV   = 6'h1D;

    function automatic logic is_alu(input logic [5:0] op);
        return op <= OP_ALU_LAST;
    endfunction

    function automatic logic is_imm(input logic [5:0] op);
        return (op >= OP_IMM_FIRST) && (op <= OP_IMM_LAST);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_JUMP) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/cycle_sequencer.sv
// Multi-cycle control FSM for CoreBassier: owns every write/enable strobe so
// that nothing in the datapath commits outside its phase.
module cycle_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       branchTaken,
    input  logic       memReady,
    input  logic       inValid,
    input  logic       outReady,
    output logic       fetchReq,
    output logic       irWrite,
    output logic       pcInc,
    output logic       pcLoad,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       inAck,
    output logic       outValid,
    output logic       halted,
    output logic       fault,
    output logic [3:0] state
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_wait, timeout;
    logic fetch_req, ir_write, pc_load, mem_read, mem_write;
    logic reg_write, in_ack, out_valid, halt_lvl, fault_lvl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        fetch_req  = 1'b0;
        ir_write   = 1'b0;
        pc_load    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        in_ack     = 1'b0;
        out_valid  = 1'b0;
        halt_lvl   = 1'b0;
        fault_lvl  = 1'b0;

        // Counter only survives while stalled in a memory-facing state, so
        // entering FETCH/MEMORY or seeing memReady restarts it at zero.
        mem_wait = ((state_q == ST_FETCH) || (state_q == ST_MEMORY)) && !memReady;
        timeout  = mem_wait && (wait_cnt_q == LIMIT);
        if (mem_wait)
            wait_cnt_d = wait_cnt_q + 1'b1;

        case (state_q)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (memReady) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (is_alu(opcode) || is_imm(opcode) || is_mem(opcode) ||
                    is_branch(opcode) || (opcode == OP_MOV))
                    state_d = ST_EXECUTE;
                else if (opcode == OP_NOP)
                    state_d = ST_FETCH;
                else if (opcode == OP_HALT)
                    state_d = ST_HALTED;
                else if (opcode == OP_IN)
                    state_d = ST_WAIT_IN;
                else if (opcode == OP_OUT)
                    state_d = ST_WAIT_OUT;
                else
                    state_d = ST_FAULT;
            end
            ST_EXECUTE: begin
                if (is_mem(opcode)) begin
                    state_d = ST_MEMORY;
                end else if (is_branch(opcode)) begin
                    pc_load = (opcode == OP_JUMP) || branchTaken;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (memReady)
                    state_d = (opcode == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
                else if (timeout)
                    state_d = ST_FAULT;
            end
            ST_WRITEBACK: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_WAIT_IN: begin
                if (inValid) begin
                    reg_write = 1'b1;
                    in_ack    = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_WAIT_OUT: begin
                out_valid = 1'b1;
                if (outReady)
                    state_d = ST_FETCH;
            end
            ST_HALTED: halt_lvl = 1'b1;
            ST_FAULT:  fault_lvl = 1'b1;
            default:   state_d = ST_FAULT;
        endcase
    end

    // Outputs are forced low while reset is held so no strobe escapes even
    // though FETCH is the reset state.
    assign fetchReq = fetch_req & reset;
    assign irWrite  = ir_write  & reset;
    assign pcInc    = ir_write  & reset;
    assign pcLoad   = pc_load   & reset;
    assign memRead  = mem_read  & reset;
    assign memWrite = mem_write & reset;
    assign regWrite = reg_write & reset;
    assign inAck    = in_ack    & reset;
    assign outValid = out_valid & reset;
    assign halted   = halt_lvl  & reset;
    assign fault    = fault_lvl & reset;
    assign state    = state_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: per-instruction cycle-by-cycle state and
// strobe checks against hand-derived expectations.
module tb_cycle_sequencer;

    logic       clock, reset;
    logic [5:0] opcode;
    logic       branchTaken, memReady, inValid, outReady;
    logic       fetchReq, irWrite, pcInc, pcLoad, memRead, memWrite;
    logic       regWrite, inAck, outValid, halted, fault;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    localparam logic [10:0] FR  = 11'h400, IRW = 11'h200, PCI = 11'h100, PCL = 11'h080;
    localparam logic [10:0] MR  = 11'h040, MW  = 11'h020, RW  = 11'h010, IA  = 11'h008;
    localparam logic [10:0] OV  = 11'h004, HL  = 11'h002, FT  = 11'h001;
    localparam logic [10:0] FET = FR | IRW | PCI;

    wire [10:0] outs = {fetchReq, irWrite, pcInc, pcLoad, memRead, memWrite,
                        regWrite, inAck, outValid, halted, fault};

    cycle_sequencer #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .branchTaken(branchTaken),
        .memReady(memReady), .inValid(inValid), .outReady(outReady),
        .fetchReq(fetchReq), .irWrite(irWrite), .pcInc(pcInc), .pcLoad(pcLoad),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .inAck(inAck),
        .outValid(outValid), .halted(halted), .fault(fault), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
    endtask

    // Runs one instruction with memReady=1, checking every cycle until back in FETCH.
    task automatic run_simple(input string name, input logic [5:0] op, input logic bt,
                              input int n, input logic [3:0] es [8], input logic [10:0] eo [8]);
        opcode = op; branchTaken = bt; memReady = 1'b1; inValid = 1'b0; outReady = 1'b0;
        for (int k = 0; k < n; k++) begin
            #1;
            total++;
            if (state !== es[k] || outs !== eo[k]) begin
                bad++;
                $display("FAIL %s c%0d: state=%0d outs=%b, required state=%0d outs=%b",
                         name, k, state, outs, es[k], eo[k]);
            end
            if (k != n - 1) tick();
        end
        $display("%s: %0d cycles checked", name, n);
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (state !== 4'd0 || outs !== 11'h000) begin
            bad++;
            $display("FAIL reset_hold: state=%0d outs=%b, required 0/0", state, outs);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || outs !== FR) begin
            bad++;
            $display("FAIL reset_release: state=%0d outs=%b, required 0/%b", state, outs, FR);
        end
        $display("reset: checked");
    endtask

    task automatic test_nop();
        logic [3:0] es [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic [10:0] eo [8] = '{FET, 0, FET, 0, 0, 0, 0, 0};
        run_simple("nop", 6'h19, 1'b0, 3, es, eo);
    endtask

    task automatic test_add();
        logic [3:0] es [8] = '{0, 1, 2, 4, 0, 0, 0, 0};
        logic [10:0] eo [8] = '{FET, 0, 0, RW, FET, 0, 0, 0};
        run_simple("add", 6'h00, 1'b1, 5, es, eo);
    endtask

    task automatic test_load();
        logic [3:0] es [8] = '{0, 1, 2, 3, 4, 0, 0, 0};
        logic [10:0] eo [8] = '{FET, 0, 0, MR, RW, FET, 0, 0};
        run_simple("load", 6'h14, 1'b0, 6, es, eo);
    endtask

    task automatic test_branch();
        logic [3:0] es [8] = '{0, 1, 2, 0, 0, 0, 0, 0};
        logic [10:0] tk [8] = '{FET, 0, PCL, FET, 0, 0, 0, 0};
        logic [10:0] nt [8] = '{FET, 0, 0, FET, 0, 0, 0, 0};
        run_simple("beq_taken", 6'h17, 1'b1, 4, es, tk);
        run_simple("beq_not_taken", 6'h17, 1'b0, 4, es, nt);
        run_simple("bne_not_taken", 6'h18, 1'b0, 4, es, nt);
        run_simple("jump_bt0", 6'h16, 1'b0, 4, es, tk);
    endtask

    task automatic test_in();
        logic [3:0] es;
        logic [10:0] eo;
        opcode = 6'h1B; branchTaken = 1'b0; outReady = 1'b0;
        for (int k = 0; k < 14; k++) begin
            memReady = (k == 0);
            inValid  = (k == 12);
            es = (k == 0) ? 4'd0 : (k == 1) ? 4'd1 : (k == 13) ? 4'd0 : 4'd5;
            eo = (k == 0 || k == 13) ? FR | ((k == 0) ? (IRW | PCI) : 11'h000)
               : (k == 12) ? (RW | IA) : 11'h000;
            #1;
            total++;
            if (state !== es || outs !== eo) begin
                bad++;
                $display("FAIL in c%0d: state=%0d outs=%b, required state=%0d outs=%b",
                         k, state, outs, es, eo);
            end
            if (k != 13) tick();
        end
        $display("in: 14 cycles checked");
    endtask

    task automatic test_out();
        logic [3:0] es;
        logic [10:0] eo;
        opcode = 6'h1C; branchTaken = 1'b0; inValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            memReady = (k == 0 || k == 7);
            outReady = (k == 6);
            es = (k == 0 || k == 7) ? 4'd0 : (k == 1) ? 4'd1 : 4'd6;
            eo = (k == 0 || k == 7) ? FET : (k == 1) ? 11'h000 : OV;
            #1;
            total++;
            if (state !== es || outs !== eo) begin
                bad++;
                $display("FAIL out c%0d: state=%0d outs=%b, required state=%0d outs=%b",
                         k, state, outs, es, eo);
            end
            if (k != 7) tick();
        end
        $display("out: 8 cycles checked");
    endtask

    // Store stalls in MEMORY; ready_cycle selects which cycle (if any) brings memReady.
    task automatic run_store_wait(input string name, input int ready_cycle,
                                  input logic [3:0] last_state, input logic [10:0] last_outs);
        logic [3:0] es;
        logic [10:0] eo;
        opcode = 6'h15; branchTaken = 1'b0; inValid = 1'b0; outReady = 1'b0;
        for (int k = 0; k < 9; k++) begin
            memReady = (k < 3) || (k == ready_cycle) || (k == 8);
            es = (k == 8) ? last_state : (k >= 3) ? 4'd3 : 4'(k);
            eo = (k == 8) ? last_outs : (k >= 3) ? MW : (k == 0) ? FET : 11'h000;
            #1;
            total++;
            if (state !== es || outs !== eo) begin
                bad++;
                $display("FAIL %s c%0d: state=%0d outs=%b, required state=%0d outs=%b",
                         name, k, state, outs, es, eo);
            end
            if (k != 8) tick();
        end
        $display("%s: 9 cycles checked", name);
    endtask

    task automatic test_timeout();
        run_store_wait("store_timeout", -1, 4'd8, FT);
        do_reset();
        run_store_wait("store_ready_at_limit", 7, 4'd0, FET);
    endtask

    task automatic test_halt();
        logic [3:0] es [8] = '{0, 1, 7, 0, 0, 0, 0, 0};
        logic [10:0] eo [8] = '{FET, 0, HL, 0, 0, 0, 0, 0};
        run_simple("halt", 6'h1A, 1'b0, 3, es, eo);
        for (int k = 0; k < 20; k++) begin
            tick();
            opcode      = 6'($urandom_range(0, 63));
            memReady    = 1'($urandom_range(0, 1));
            inValid     = 1'($urandom_range(0, 1));
            outReady    = 1'($urandom_range(0, 1));
            branchTaken = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (state !== 4'd7 || outs !== HL) begin
                bad++;
                $display("FAIL halt_hold c%0d: state=%0d outs=%b, required 7/%b", k, state, outs, HL);
            end
        end
        $display("halt_hold: 20 cycles checked");
        do_reset();
    endtask

    task automatic test_illegal();
        logic [3:0] es [8] = '{0, 1, 8, 8, 0, 0, 0, 0};
        logic [10:0] eo [8] = '{FET, 0, FT, FT, 0, 0, 0, 0};
        run_simple("illegal_3f", 6'h3F, 1'b0, 4, es, eo);
        do_reset();
        run_simple("illegal_1e", 6'h1E, 1'b0, 4, es, eo);
        do_reset();
    endtask

    task automatic test_reset_mid_memory();
        opcode = 6'h14; branchTaken = 1'b0; inValid = 1'b0; outReady = 1'b0;
        memReady = 1'b1;
        tick(); tick(); tick();
        memReady = 1'b0;
        tick(); tick();
        #1;
        total++;
        if (state !== 4'd3 || outs !== MR) begin
            bad++;
            $display("FAIL rst_mem_pre: state=%0d outs=%b, required 3/%b", state, outs, MR);
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || outs !== 11'h000) begin
            bad++;
            $display("FAIL rst_mem_async: state=%0d outs=%b, required 0/0", state, outs);
        end
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || outs !== FR) begin
            bad++;
            $display("FAIL rst_mem_release: state=%0d outs=%b, required 0/%b", state, outs, FR);
        end
        $display("reset_mid_memory: checked");
    endtask

    initial begin
        reset = 1'b0; opcode = 6'h00; branchTaken = 1'b0;
        memReady = 1'b0; inValid = 1'b0; outReady = 1'b0;
        test_reset();
        test_nop();
        test_add();
        test_load();
        test_branch();
        test_in();
        test_out();
        test_timeout();
        test_halt();
        test_illegal();
        test_reset_mid_memory();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Multi-cycle FSM that sequences the CoreBassier datapath one instruction at a time: FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Handles the memory ready handshake, the In/Out device handshakes, HALT, and a memory-wait timeout fault.
- Sits beside the opcode decoder: the decoder supplies the static mux selects, and this block supplies every write/enable strobe, so nothing commits outside its phase.

Parameters:
- WAIT_LIMIT, 255: max cycles to wait for memReady in FETCH or MEMORY before entering FAULT.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- branchTaken  in  1  ALU compare result, already sense-corrected for beq/bne; sampled in EXECUTE.
- memReady  in  1  memory completes the current fetch/read/write this cycle.
- inValid  in  1  input device holds a valid word.
- outReady  in  1  output device accepts the word.
- fetchReq  out  1  instruction memory read request.
- irWrite  out  1  load IR.
- pcInc  out  1  PC <= PC+1.
- pcLoad  out  1  PC <= branch/jump target.
- memRead  out  1  data memory read request.
- memWrite  out  1  data memory write request.
- regWrite  out  1  register-file write enable.
- inAck  out  1  input word consumed.
- outValid  out  1  output word presented.
- halted  out  1  in HALTED.
- fault  out  1  in FAULT.
- state  out  4  current state encoding, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, WAIT_IN=5, WAIT_OUT=6, HALTED=7, FAULT=8.
- Reset (async, reset=0): state=FETCH, waitCount=0, all strobes 0, halted=0, fault=0. Reset wins over any in-flight wait.
- Level outputs are pure state decode:
  - fetchReq = FETCH
  - memRead = MEMORY and load
  - memWrite = MEMORY and store
  - outValid = WAIT_OUT
  - halted = HALTED
  - fault = FAULT
- Single-cycle strobes are Mealy, from registered state plus inputs:
  - irWrite = pcInc = FETCH and memReady.
  - pcLoad = EXECUTE and (jump, or (beq/bne and branchTaken)).
  - regWrite = WRITEBACK, or (WAIT_IN and inValid).
  - inAck = WAIT_IN and inValid.
- Transitions:
  - FETCH: to DECODE when memReady.
  - DECODE, by opcode:
    - 0x00-0x13 (ALU/imm), 0x14 load, 0x15 store, 0x16-0x18 jump/beq/bne, 0x1D mov: to EXECUTE.
    - 0x19 nop: to FETCH.
    - 0x1A halt: to HALTED.
    - 0x1B in: to WAIT_IN.
    - 0x1C out: to WAIT_OUT.
    - 0x1E-0x3F: to FAULT (illegal opcode).
  - EXECUTE: load/store to MEMORY; jump/branch to FETCH; ALU/mov to WRITEBACK.
  - MEMORY: on memReady, load goes to WRITEBACK and store goes to FETCH.
  - WRITEBACK: to FETCH.
  - WAIT_IN: to FETCH when inValid. No timeout.
  - WAIT_OUT: to FETCH when outReady. No timeout.
  - HALTED, FAULT: terminal until reset.
- Latency per instruction, with memReady=1 first cycle:
  - nop 2; jump/branch 3; ALU/mov 4; store 4; load 5.
  - in/out: 3 when the device is ready in the first wait cycle.
- Wait counter:
  - Clears on entry to FETCH/MEMORY and whenever memReady=1.
  - Increments each cycle spent in FETCH/MEMORY with memReady=0.
  - When waitCount==WAIT_LIMIT and memReady=0: go to FAULT on the next edge.
  - memReady arriving in the limit cycle has priority; no fault.
- opcode is sampled fresh in each state; the IR holds it stable.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams OP_ADD..OP_MOV, matching the decoder's values.
  - state enum/localparams.
  - class helpers is_alu, is_imm, is_mem, is_branch.
- No sub-module; one always_ff for state and counter plus one always_comb for next-state and outputs.

Test Plan:
- Reset mid-MEMORY: load with memReady=0 for 3 cycles, reset=0 -> state=0 and all outputs 0 the same cycle, asynchronously. Release -> fetchReq=1.
- Add (0x00), memReady=1 throughout -> irWrite at cycle 0, regWrite exactly one pulse at cycle 3, back in FETCH at cycle 4. Load (0x14) -> memRead at cycle 3, regWrite at cycle 4.
- beq (0x17) with branchTaken=1 -> pcLoad=1 only in EXECUTE. branchTaken=0 -> pcLoad never asserted. Jump (0x16) -> pcLoad ignores branchTaken.
- In (0x1B), inValid low for 10 cycles then high -> state=5 for 10 cycles, then inAck=regWrite=1 for 1 cycle, then FETCH. Out (0x1C) with outReady delayed 4 cycles -> outValid high 5 cycles.
- Timeout: WAIT_LIMIT=4, store with memReady held 0 -> fault=1 after 5 MEMORY cycles, state=8, memWrite drops. Repeat with memReady=1 in the 5th cycle -> no fault.
- Halt (0x1A) -> halted=1 and stays; fetchReq=0 for 20 cycles regardless of inputs. Opcode 0x3F -> fault=1.
